// File: rtl/storebuffer_pkg.sv
// Shared types for the store buffer slice (package wires).
//   mem_in_type            : core/memory request {valid, fence, instr, addr, wdata, wstrb}
//   mem_out_type           : core/memory response {ready, rdata}
//   storebuffer_entry_type : one buffered store {valid, addr, wdata, wstrb}
//   storebuffer_state_type : memory-port FSM states
//   init_storebuffer_entry : reset value of a buffer entry
package wires;

   typedef struct packed {
      logic        mem_valid;
      logic        mem_fence;
      logic        mem_instr;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic        mem_ready;
      logic [31:0] mem_rdata;
   } mem_out_type;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } storebuffer_entry_type;

   typedef enum logic [1:0] {
      SB_IDLE,
      SB_LOAD,
      SB_DRAIN,
      SB_FENCE
   } storebuffer_state_type;

   localparam storebuffer_entry_type init_storebuffer_entry = '{
      valid : 1'b0,
      addr  : '0,
      wdata : '0,
      wstrb : '0
   };

endpackage

// File: rtl/storebuffer_fifo.sv
// In-order store FIFO with per-entry word-address alias detection.
//   clk, rst (sync, active-low)
//   enq / enq_entry  : push a store at the tail
//   deq              : pop the head entry
//   match_addr       : address compared (word granularity) against valid entries
//   head_entry       : oldest buffered store
//   count            : number of valid entries (0..DEPTH)
//   match_any        : some valid entry aliases match_addr
//   fwd_hit/fwd_data : youngest aliasing entry is a full-word store, and its data
//                      (only with STOREBUFFER_FWD_EN defined)
module storebuffer_fifo
   import wires::*;
#(
   parameter int unsigned DEPTH = 4
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enq,
   input  storebuffer_entry_type       enq_entry,
   input  logic                        deq,
   input  logic [31:0]                 match_addr,
   output storebuffer_entry_type       head_entry,
   output logic [$clog2(DEPTH):0]      count,
`ifdef STOREBUFFER_FWD_EN
   output logic                        fwd_hit,
   output logic [31:0]                 fwd_data,
`endif
   output logic                        match_any
);

   localparam int unsigned PW = $clog2(DEPTH);

   storebuffer_entry_type entries [DEPTH];
   logic [PW-1:0]         head_ptr;
   logic [PW-1:0]         tail_ptr;
   logic [DEPTH-1:0]      match_vec;
   logic [1:0]            unused_addr_lo;

   assign unused_addr_lo = match_addr[1:0];
   assign head_entry     = entries[head_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i] <= init_storebuffer_entry;
         end
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         // Dequeue is written before enqueue: when full, head==tail and the
         // freed slot is refilled in the same cycle, so the new valid must win.
         if (deq) begin
            entries[head_ptr].valid <= 1'b0;
            head_ptr                <= head_ptr + PW'(1);
         end
         if (enq) begin
            entries[tail_ptr]       <= enq_entry;
            entries[tail_ptr].valid <= 1'b1;
            tail_ptr                <= tail_ptr + PW'(1);
         end
         case ({enq, deq})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      match_vec = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         match_vec[i] = entries[i].valid && (entries[i].addr[31:2] == match_addr[31:2]);
      end
   end

   assign match_any = |match_vec;

`ifdef STOREBUFFER_FWD_EN
   logic [PW-1:0] idx;

   // Walk oldest to youngest so the last hit is the youngest alias.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_ptr + PW'(i);
         if (match_vec[idx]) begin
            fwd_hit  = (entries[idx].wstrb == 4'hF);
            fwd_data = entries[idx].wdata;
         end
      end
   end
`endif

endmodule

// File: rtl/storebuffer.sv
// Write-back store buffer between the core request port and data memory.
//   clk, rst (sync, active-low)
//   storebuffer_in  : core request (one outstanding at a time)
//   storebuffer_out : core response, registered one-cycle ready pulse + rdata
//   dmem_in         : registered request to data memory, stable while busy
//   dmem_out        : data-memory response
// Optional feature: define STOREBUFFER_FWD_EN to answer loads from the youngest
// aliasing full-word buffered store without a memory access.
module storebuffer
   import wires::*;
#(
   parameter int unsigned DEPTH = 4
)
(
   input  logic        clk,
   input  logic        rst,
   input  mem_in_type  storebuffer_in,
   output mem_out_type storebuffer_out,
   output mem_in_type  dmem_in,
   input  mem_out_type dmem_out
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   storebuffer_state_type state, state_n;
   mem_in_type            pend, pend_n;
   logic                  pend_valid, pend_valid_n;
   mem_in_type            dmem_r, dmem_n;
   mem_out_type           resp_r, resp_n;

   mem_in_type            req;
   logic                  req_valid;
   logic                  is_fence, is_store, is_load;
   logic                  enq, deq, can_enq;
   storebuffer_entry_type enq_entry, head_entry;
   logic [PW:0]           count;
   logic                  match_any;
   logic                  unused_instr;
`ifdef STOREBUFFER_FWD_EN
   logic                  fwd_hit;
   logic [31:0]           fwd_data;
`endif

   // A new request is acted on in its own cycle; PEND only carries it onward.
   assign req_valid    = storebuffer_in.mem_valid | pend_valid;
   assign req          = storebuffer_in.mem_valid ? storebuffer_in : pend;
   assign is_fence     = req.mem_fence;
   assign is_store     = !req.mem_fence && (req.mem_wstrb != 4'h0);
   assign is_load      = !req.mem_fence && (req.mem_wstrb == 4'h0);
   assign unused_instr = req.mem_instr;

   assign deq     = (state == SB_DRAIN) && dmem_out.mem_ready;
   assign can_enq = (count != FULL) || deq;

   assign enq_entry = '{valid : 1'b1, addr : req.mem_addr,
                        wdata : req.mem_wdata, wstrb : req.mem_wstrb};

   storebuffer_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .enq        (enq),
      .enq_entry  (enq_entry),
      .deq        (deq),
      .match_addr (req.mem_addr),
      .head_entry (head_entry),
      .count      (count),
`ifdef STOREBUFFER_FWD_EN
      .fwd_hit    (fwd_hit),
      .fwd_data   (fwd_data),
`endif
      .match_any  (match_any)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= SB_IDLE;
         pend       <= '0;
         pend_valid <= 1'b0;
         dmem_r     <= '0;
         resp_r     <= '0;
      end else begin
         state      <= state_n;
         pend       <= pend_n;
         pend_valid <= pend_valid_n;
         dmem_r     <= dmem_n;
         resp_r     <= resp_n;
      end
   end

   always_comb begin
      state_n          = state;
      pend_n           = pend;
      pend_valid_n     = pend_valid;
      dmem_n           = dmem_r;
      resp_n           = resp_r;
      resp_n.mem_ready = 1'b0;
      enq              = 1'b0;

      if (storebuffer_in.mem_valid) begin
         pend_n       = storebuffer_in;
         pend_valid_n = 1'b1;
      end

      if (req_valid && is_store && can_enq) begin
         enq          = 1'b1;
         pend_valid_n = 1'b0;
         resp_n       = '{mem_ready : 1'b1, mem_rdata : '0};
      end

`ifdef STOREBUFFER_FWD_EN
      if (req_valid && is_load && (state != SB_LOAD) && fwd_hit) begin
         pend_valid_n = 1'b0;
         resp_n       = '{mem_ready : 1'b1, mem_rdata : fwd_data};
      end
`endif

      case (state)
         SB_IDLE: begin
            // fwd_hit implies match_any, so a forwarded load never issues here.
            if (req_valid && is_load && !match_any) begin
               state_n          = SB_LOAD;
               dmem_n           = '0;
               dmem_n.mem_valid = 1'b1;
               dmem_n.mem_addr  = req.mem_addr;
            end else if (count != '0) begin
               state_n          = SB_DRAIN;
               dmem_n           = '0;
               dmem_n.mem_valid = head_entry.valid;
               dmem_n.mem_addr  = head_entry.addr;
               dmem_n.mem_wdata = head_entry.wdata;
               dmem_n.mem_wstrb = head_entry.wstrb;
            end else if (req_valid && is_fence) begin
               state_n          = SB_FENCE;
               dmem_n           = '0;
               dmem_n.mem_valid = 1'b1;
               dmem_n.mem_fence = 1'b1;
            end
         end
         SB_LOAD: begin
            if (dmem_out.mem_ready) begin
               state_n      = SB_IDLE;
               dmem_n       = '0;
               pend_valid_n = 1'b0;
               resp_n       = '{mem_ready : 1'b1, mem_rdata : dmem_out.mem_rdata};
            end
         end
         SB_DRAIN: begin
            if (dmem_out.mem_ready) begin
               state_n = SB_IDLE;
               dmem_n  = '0;
            end
         end
         SB_FENCE: begin
            if (dmem_out.mem_ready) begin
               state_n      = SB_IDLE;
               dmem_n       = '0;
               pend_valid_n = 1'b0;
               resp_n       = '{mem_ready : 1'b1, mem_rdata : '0};
            end
         end
         default: begin
            state_n = SB_IDLE;
            dmem_n  = '0;
         end
      endcase
   end

   assign dmem_in         = dmem_r;
   assign storebuffer_out = resp_r;

endmodule

// File: tb/tb_storebuffer.sv
// Self-checking bench for storebuffer: directed scenarios plus randomized
// traffic checked against a program-order shadow memory.
module tb_storebuffer;
   import wires::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   mem_in_type  sb_in;
   mem_out_type sb_out;
   mem_in_type  dmem_in;
   mem_out_type dmem_out;

   storebuffer #(.DEPTH(4)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .storebuffer_in  (sb_in),
      .storebuffer_out (sb_out),
      .dmem_in         (dmem_in),
      .dmem_out        (dmem_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- memory images ----------------
   logic [31:0] mem    [logic [29:0]];
   logic [31:0] shadow [logic [29:0]];

   function automatic logic [31:0] mem_init(input logic [29:0] w);
      return {w[15:0], 16'hA5C3};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [29:0] w);
      return mem.exists(w) ? mem[w] : mem_init(w);
   endfunction

   function automatic logic [31:0] sh_rd(input logic [29:0] w);
      return shadow.exists(w) ? shadow[w] : mem_init(w);
   endfunction

   // ---------------- memory responder ----------------
   typedef struct {
      int          kind;   // 0 read, 1 write, 2 fence
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          iss;
      int          ack;
   } txn_t;

   txn_t log_q[$];
   txn_t rsp_t;
   int   mem_lat = 0;
   int   wcnt    = 0;
   int   iss_c   = 0;

   initial dmem_out = '0;

   always @(posedge clk) begin
      #1;
      dmem_out.mem_ready = 1'b0;
      if (!dmem_in.mem_valid) begin
         wcnt = 0;
      end else begin
         if (wcnt == 0) iss_c = cyc;
         if (wcnt >= mem_lat) begin
            rsp_t.kind = dmem_in.mem_fence ? 2 : ((dmem_in.mem_wstrb != 4'h0) ? 1 : 0);
            rsp_t.addr = dmem_in.mem_addr;
            rsp_t.data = dmem_in.mem_wdata;
            rsp_t.strb = dmem_in.mem_wstrb;
            rsp_t.iss  = iss_c;
            rsp_t.ack  = cyc;
            if (rsp_t.kind == 1)
               mem[rsp_t.addr[31:2]] = merge(mem_rd(rsp_t.addr[31:2]), rsp_t.data, rsp_t.strb);
            else if (rsp_t.kind == 0)
               dmem_out.mem_rdata = mem_rd(rsp_t.addr[31:2]);
            log_q.push_back(rsp_t);
            dmem_out.mem_ready = 1'b1;
            wcnt = 0;
         end else begin
            wcnt++;
         end
      end
   end

   // ---------------- core driver ----------------
   logic [67:0] exp_w[$];   // {addr, data, strb} of every store in program order

   task automatic do_req(input logic fence, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, output int lat, output logic [31:0] rdata,
                         output int rcyc);
      sb_in           = '0;
      sb_in.mem_valid = 1'b1;
      sb_in.mem_fence = fence;
      sb_in.mem_addr  = addr;
      sb_in.mem_wdata = wdata;
      sb_in.mem_wstrb = fence ? 4'h0 : strb;
      if (!fence && strb != 4'h0) begin
         shadow[addr[31:2]] = merge(sh_rd(addr[31:2]), wdata, strb);
         exp_w.push_back({addr, wdata, strb});
      end
      lat   = -1;
      rdata = '0;
      rcyc  = -1;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk); #1;
         sb_in = '0;
         if (sb_out.mem_ready) begin
            lat   = i;
            rdata = sb_out.mem_rdata;
            rcyc  = cyc;
            break;
         end
      end
      check("req_done", lat > 0, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(posedge clk); #1;
         if (!dmem_in.mem_valid && u_dut.u_fifo.count == 0) done = 1'b1;
      end
      check("idle_reached", done, 1'b1);
      @(posedge clk); #1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scenarios ----------------
   initial begin
      int          lat, rc, base, ridx, widx, nwr;
      logic [31:0] rd;
      logic [31:0] a;
      logic [3:0]  s;
      txn_t        wl[$];

      sb_in = '0;
      rst   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", sb_out.mem_ready, 1'b0);
      check("rst_rdata", sb_out.mem_rdata, 32'h0);
      check("rst_dmem",  dmem_in, '0);
      check("rst_count", u_dut.u_fifo.count, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // four stores, fast memory
      mem_lat = 0;
      base = log_q.size();
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, 32'h100 + 32'(4*i), 32'h1111_0000 + 32'(i), 4'hF, lat, rd, rc);
         check("st_lat", lat, 1);
      end
      wait_idle();
      check("st4_n", log_q.size() - base, 4);
      if (log_q.size() >= base + 4)
         for (int i = 0; i < 4; i++)
            check("st4_order", {log_q[base+i].kind[1:0], log_q[base+i].addr}, {2'd1, 32'h100 + 32'(4*i)});
      check("drain_count", u_dut.u_fifo.count, 0);

      // full buffer, slow memory
      mem_lat = 10;
      base = log_q.size();
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, 32'h140 + 32'(4*i), 32'h2222_0000 + 32'(i), 4'hF, lat, rd, rc);
         check("fill_lat", lat, 1);
      end
      do_req(1'b0, 32'h150, 32'h2222_0004, 4'hF, lat, rd, rc);
      if (log_q.size() > base) check("full_ready", rc, log_q[base].ack + 1);
      else                     check("full_ack_seen", log_q.size(), base + 1);
      wait_idle();
      check("full_n", log_q.size() - base, 5);
      if (log_q.size() >= base + 5)
         for (int i = 0; i < 5; i++)
            check("full_order", log_q[base+i].addr, 32'h140 + 32'(4*i));

      // store then aliasing load
      mem_lat = 8;
      base = log_q.size();
      do_req(1'b0, 32'h200, 32'hDEADBEEF, 4'hF, lat, rd, rc);
      do_req(1'b0, 32'h200, 32'h0, 4'h0, lat, rd, rc);
      check("alias_data", rd, 32'hDEADBEEF);
      wait_idle();
`ifdef STOREBUFFER_FWD_EN
      check("fwd_lat", lat, 1);
      ridx = 0;
      for (int i = base; i < log_q.size(); i++) if (log_q[i].kind == 0) ridx++;
      check("fwd_noread", ridx, 0);
`else
      ridx = 9999; widx = -1;
      for (int i = base; i < log_q.size(); i++) begin
         if (log_q[i].kind == 1 && log_q[i].addr == 32'h200) widx = i;
         if (log_q[i].kind == 0 && log_q[i].addr == 32'h200) ridx = i;
      end
      check("alias_found", (widx >= 0) && (ridx != 9999), 1'b1);
      if ((widx >= 0) && (ridx != 9999))
         check("alias_after_wr", log_q[ridx].iss > log_q[widx].ack, 1'b1);
`endif

      // non-aliasing load bypasses a buffered store
      mem_lat = 6;
      base = log_q.size();
      do_req(1'b0, 32'h2F0, 32'h3333_0000, 4'hF, lat, rd, rc);
      do_req(1'b0, 32'h300, 32'h3333_0001, 4'hF, lat, rd, rc);
      do_req(1'b0, 32'h400, 32'h0, 4'h0, lat, rd, rc);
      check("bypass_data", rd, sh_rd(30'h100));
      wait_idle();
      ridx = 9999; widx = -1;
      for (int i = base; i < log_q.size(); i++) begin
         if (log_q[i].kind == 1 && log_q[i].addr == 32'h300) widx = i;
         if (log_q[i].kind == 0 && log_q[i].addr == 32'h400) ridx = i;
      end
      check("bypass_order", ridx < widx, 1'b1);

      // fence after two buffered stores
      mem_lat = 3;
      base = log_q.size();
      do_req(1'b0, 32'h500, 32'h4444_0000, 4'hF, lat, rd, rc);
      do_req(1'b0, 32'h504, 32'h4444_0001, 4'h3, lat, rd, rc);
      do_req(1'b1, 32'h0,   32'h0,         4'h0, lat, rd, rc);
      wait_idle();
      check("fence_n", log_q.size() - base, 3);
      if (log_q.size() >= base + 3) begin
         check("fence_seq", {log_q[base].kind[1:0], log_q[base+1].kind[1:0], log_q[base+2].kind[1:0]},
               {2'd1, 2'd1, 2'd2});
         check("fence_ready", rc, log_q[base+2].ack + 1);
      end

      // reset during an in-flight load
      mem_lat = 20;
      base = log_q.size();
      sb_in           = '0;
      sb_in.mem_valid = 1'b1;
      sb_in.mem_addr  = 32'h600;
      @(posedge clk); #1;
      sb_in = '0;
      check("ld_issue_t1", {dmem_in.mem_valid, dmem_in.mem_addr}, {1'b1, 32'h600});
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("rstmid_dmem",  dmem_in, '0);
      check("rstmid_ready", sb_out.mem_ready, 1'b0);
      check("rstmid_count", u_dut.u_fifo.count, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rstmid_noack", log_q.size() - base, 0);
      mem_lat = 2;
      do_req(1'b0, 32'h604, 32'h0, 4'h0, lat, rd, rc);
      check("post_rst_data", rd, sh_rd(30'h181));
      check("post_rst_lat", lat, 4);

      // randomized traffic against the shadow memory
      for (int n = 0; n < 300; n++) begin
         mem_lat = $urandom_range(0, 4);
         a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         case ($urandom_range(0, 9))
            0: do_req(1'b1, 32'h0, 32'h0, 4'h0, lat, rd, rc);
            1, 2, 3, 4, 5: begin
               s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(1, 15));
               do_req(1'b0, a, $urandom, s, lat, rd, rc);
            end
            default: begin
               do_req(1'b0, a, 32'h0, 4'h0, lat, rd, rc);
               check("rnd_load", rd, sh_rd(a[31:2]));
            end
         endcase
      end
      do_req(1'b1, 32'h0, 32'h0, 4'h0, lat, rd, rc);
      wait_idle();
      for (int i = 0; i < 8; i++) begin
         a = 32'h1000 + 32'(4*i);
         check("mem_img", mem_rd(a[31:2]), sh_rd(a[31:2]));
      end

      // every store reached memory exactly once, in program order
      foreach (log_q[i]) if (log_q[i].kind == 1) wl.push_back(log_q[i]);
      nwr = wl.size();
      check("wr_count", nwr, exp_w.size());
      for (int i = 0; i < nwr && i < exp_w.size(); i++)
         check("wr_order", {wl[i].addr, wl[i].data, wl[i].strb}, exp_w[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
